// File: rtl/dec_4_16_seq_if.sv
// Handshake and output bundle for the registered 4-to-16 decoder.
// The requester drives the code and control lines; the decoder drives the one-hot word and status.
interface dec_4_16_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  A;
   logic        sweep;
   logic [15:0] Y;
   logic        y_valid;
   logic        busy;
   logic        done;

   modport master (
      output in_valid, A, sweep,
      input  in_ready, Y, y_valid, busy, done
   );

   modport slave (
      input  in_valid, A, sweep,
      output in_ready, Y, y_valid, busy, done
   );
endinterface

// File: rtl/dec_4_16_seq.sv
// Registered 4-to-16 one-hot decoder with a HOLD-cycle output window and an automatic 0..15 sweep.
// ACTIVE_LOW inverts the whole Y bus, idle level included.
module dec_4_16_seq #(
   parameter int unsigned HOLD       = 4,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   dec_4_16_seq_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HOLD  = 2'd1,
      S_SWEEP = 2'd2
   } state_t;

   localparam logic [7:0]  CNT_LOAD = 8'(HOLD - 1);
   localparam logic [15:0] Y_IDLE   = ACTIVE_LOW ? 16'hFFFF : 16'h0000;

   function automatic logic [15:0] line_word(input logic [3:0] k);
      logic [15:0] oh_s;
      oh_s = 16'h0001 << k;
      return ACTIVE_LOW ? ~oh_s : oh_s;
   endfunction

   state_t      state_r;
   logic [7:0]  cnt_r;
   logic [3:0]  idx_r;
   logic [15:0] y_r;
   logic        y_valid_r;
   logic        busy_r;
   logic        done_r;

   // Decoder sequencer: accept/sweep in IDLE, count out the hold window, pulse done on return.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= S_IDLE;
         cnt_r     <= 8'd0;
         idx_r     <= 4'd0;
         y_r       <= Y_IDLE;
         y_valid_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               // sweep wins over a simultaneous in_valid, which must be held for a retry
               if (bus.sweep) begin
                  state_r   <= S_SWEEP;
                  idx_r     <= 4'd0;
                  y_r       <= line_word(4'd0);
                  y_valid_r <= 1'b1;
                  busy_r    <= 1'b1;
                  cnt_r     <= CNT_LOAD;
               end else if (bus.in_valid) begin
                  state_r   <= S_HOLD;
                  idx_r     <= bus.A;
                  y_r       <= line_word(bus.A);
                  y_valid_r <= 1'b1;
                  busy_r    <= 1'b1;
                  cnt_r     <= CNT_LOAD;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_HOLD: begin
               if (cnt_r != 8'd0) begin
                  cnt_r <= cnt_r - 8'd1;
               end else begin
                  state_r   <= S_IDLE;
                  y_r       <= Y_IDLE;
                  y_valid_r <= 1'b0;
                  busy_r    <= 1'b0;
                  done_r    <= 1'b1;
               end
            end
            S_SWEEP: begin
               if (cnt_r != 8'd0) begin
                  cnt_r <= cnt_r - 8'd1;
               end else if (idx_r != 4'd15) begin
                  idx_r <= idx_r + 4'd1;
                  y_r   <= line_word(idx_r + 4'd1);
                  cnt_r <= CNT_LOAD;
               end else begin
                  state_r   <= S_IDLE;
                  y_r       <= Y_IDLE;
                  y_valid_r <= 1'b0;
                  busy_r    <= 1'b0;
                  done_r    <= 1'b1;
               end
            end
            default: begin
               state_r   <= S_IDLE;
               cnt_r     <= 8'd0;
               idx_r     <= 4'd0;
               y_r       <= Y_IDLE;
               y_valid_r <= 1'b0;
               busy_r    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready = (state_r == S_IDLE);
   assign bus.Y        = y_r;
   assign bus.y_valid  = y_valid_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;

endmodule

// File: tb/tb_dec_4_16_seq.sv
// Directed, table-driven bench for dec_4_16_seq: single decodes, back-to-back, sweep, priority,
// active-low polarity and asynchronous reset in mid-operation.
module tb_dec_4_16_seq;

   logic clk;
   logic rst;

   dec_4_16_seq_if b4 ();
   dec_4_16_seq_if b2 ();
   dec_4_16_seq_if bl ();

   dec_4_16_seq #(.HOLD(4), .ACTIVE_LOW(1'b0)) dut_h4 (.clk(clk), .rst(rst), .bus(b4));
   dec_4_16_seq #(.HOLD(2), .ACTIVE_LOW(1'b0)) dut_h2 (.clk(clk), .rst(rst), .bus(b2));
   dec_4_16_seq #(.HOLD(1), .ACTIVE_LOW(1'b1)) dut_al (.clk(clk), .rst(rst), .bus(bl));

   typedef struct {
      logic [3:0]  code;
      logic [15:0] y_exp;
   } vec_t;

   int n_checks;
   int n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   vec_t vecs [6];

   initial begin
      logic [15:0] one_s;
      logic [15:0] exp_s;
      int          seen_done;

      n_checks = 0;
      n_fail   = 0;
      one_s    = 16'h0001;
      vecs[0]  = '{code: 4'd5,  y_exp: 16'h0020};
      vecs[1]  = '{code: 4'd0,  y_exp: 16'h0001};
      vecs[2]  = '{code: 4'd15, y_exp: 16'h8000};
      vecs[3]  = '{code: 4'd9,  y_exp: 16'h0200};
      vecs[4]  = '{code: 4'd3,  y_exp: 16'h0008};
      vecs[5]  = '{code: 4'd12, y_exp: 16'h1000};

      b4.in_valid = 1'b0; b4.A = 4'd0; b4.sweep = 1'b0;
      b2.in_valid = 1'b0; b2.A = 4'd0; b2.sweep = 1'b0;
      bl.in_valid = 1'b0; bl.A = 4'd0; bl.sweep = 1'b0;
      rst = 1'b1;
      #1;
      chk("reset_y",       b4.Y,                 16'h0000);
      chk("reset_yvalid",  {15'd0, b4.y_valid},  16'd0);
      chk("reset_busy",    {15'd0, b4.busy},     16'd0);
      chk("reset_done",    {15'd0, b4.done},     16'd0);
      chk("reset_ready",   {15'd0, b4.in_ready}, 16'd1);
      chk("reset_al_y",    bl.Y,                 16'hFFFF);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // single decodes, HOLD=4; A is scrambled after accept and must not matter
      for (int v = 0; v < 6; v++) begin
         b4.in_valid = 1'b1;
         b4.A        = vecs[v].code;
         tick();
         b4.in_valid = 1'b0;
         b4.A        = ~vecs[v].code;
         chk("single_y_first", b4.Y,                 vecs[v].y_exp);
         chk("single_ready_lo", {15'd0, b4.in_ready}, 16'd0);
         chk("single_busy",    {15'd0, b4.busy},     16'd1);
         for (int c = 1; c < 4; c++) begin
            tick();
            chk("single_y_hold",  b4.Y,                vecs[v].y_exp);
            chk("single_yvalid",  {15'd0, b4.y_valid}, 16'd1);
            chk("single_no_done", {15'd0, b4.done},    16'd0);
         end
         tick();
         chk("single_y_idle",  b4.Y,                 16'h0000);
         chk("single_done",    {15'd0, b4.done},     16'd1);
         chk("single_ready",   {15'd0, b4.in_ready}, 16'd1);
         chk("single_yv_lo",   {15'd0, b4.y_valid},  16'd0);
         tick();
         chk("single_done_1cy", {15'd0, b4.done},    16'd0);
      end

      // back-to-back: A=0 then A=15 with in_valid held, second accepted in the done cycle
      b4.in_valid = 1'b1;
      b4.A        = 4'd0;
      tick();
      b4.A = 4'd15;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) tick();
         chk("b2b_first", b4.Y, 16'h0001);
      end
      tick();
      chk("b2b_gap_y",    b4.Y,             16'h0000);
      chk("b2b_gap_done", {15'd0, b4.done}, 16'd1);
      tick();
      b4.in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) tick();
         chk("b2b_second", b4.Y, 16'h8000);
      end
      tick();
      chk("b2b_end_done", {15'd0, b4.done}, 16'd1);
      tick();

      // sweep with a simultaneous in_valid (A=7) on HOLD=2: sweep wins, 7 accepted afterwards
      b2.sweep    = 1'b1;
      b2.in_valid = 1'b1;
      b2.A        = 4'd7;
      tick();
      b2.sweep = 1'b0;
      for (int k = 0; k < 32; k++) begin
         if (k > 0) tick();
         exp_s = one_s << (k / 2);
         chk("sweep_y",    b2.Y,                exp_s);
         chk("sweep_busy", {15'd0, b2.busy},    16'd1);
         chk("sweep_ndone", {15'd0, b2.done},   16'd0);
      end
      tick();
      chk("sweep_end_y",     b2.Y,                 16'h0000);
      chk("sweep_end_done",  {15'd0, b2.done},     16'd1);
      chk("sweep_end_ready", {15'd0, b2.in_ready}, 16'd1);
      tick();
      b2.in_valid = 1'b0;
      chk("retry_code7", b2.Y, 16'h0080);
      tick();
      chk("retry_code7_hold", b2.Y, 16'h0080);
      tick();
      chk("retry_done", {15'd0, b2.done}, 16'd1);

      // asynchronous reset mid-hold on HOLD=4, no clock edge needed
      b4.in_valid = 1'b1;
      b4.A        = 4'd5;
      tick();
      b4.in_valid = 1'b0;
      chk("pre_rst_y", b4.Y, 16'h0020);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_y",     b4.Y,                 16'h0000);
      chk("async_rst_yv",    {15'd0, b4.y_valid},  16'd0);
      chk("async_rst_ready", {15'd0, b4.in_ready}, 16'd1);
      tick();
      rst = 1'b0;
      tick();

      // active-low, HOLD=1
      bl.in_valid = 1'b1;
      bl.A        = 4'd2;
      tick();
      bl.in_valid = 1'b0;
      chk("al_word", bl.Y, 16'hFFFB);
      tick();
      chk("al_idle", bl.Y,             16'hFFFF);
      chk("al_done", {15'd0, bl.done}, 16'd1);
      tick();

      // active-low sweep interrupted by reset at idx=9
      bl.sweep = 1'b1;
      tick();
      bl.sweep = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) tick();
         exp_s = ~(one_s << k);
         chk("al_sweep_y", bl.Y, exp_s);
      end
      #2;
      rst = 1'b1;
      #1;
      chk("al_rst_y",    bl.Y,                 16'hFFFF);
      chk("al_rst_done", {15'd0, bl.done},     16'd0);
      chk("al_rst_busy", {15'd0, bl.busy},     16'd0);
      tick();
      rst = 1'b0;
      seen_done = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (bl.done) seen_done++;
      end
      chk("al_no_done_after_rst", 16'(seen_done), 16'd0);
      chk("al_idle_after_rst",    bl.Y,           16'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
